bbox_scan: RTL and testbench
============================

# bbox_scan

Upstream stage of the cropping path: scans a row-major 8-bit grayscale image held in a synchronous-read pixel memory and finds the tight bounding box of all foreground (dark) pixels. On completion it presents x_min/x_max/y_min/y_max plus a found flag, which the crop stage consumes as its source window. Single pass, one pixel per clock, start/done handshake.

## Interface

Parameters:
- WIDTH, 256: image width in pixels (≥2)
- HEIGHT, 256: image height in pixels (≥2)
- THRESHOLD, 8'd128: pixel is foreground when pix < THRESHOLD (unsigned)
- MARGIN, 2: padding in pixels added per side when BBOX_MARGIN_EN is defined

Ports (XW = $clog2(WIDTH), YW = $clog2(HEIGHT), AW = $clog2(WIDTH*HEIGHT)):
- CLOCK_50  in  1  sole clock, rising edge
- KEY  in  4  KEY[3] = reset, asynchronous, active-low; KEY[2:0] unused
- start  in  1  begin scan (sampled in IDLE or DONE)
- rd_addr  out  AW  pixel memory read address, y*WIDTH + x
- rd_data  in  8  pixel from memory, valid one cycle after rd_addr
- x_min, x_max  out  XW  bounding box columns (inclusive)
- y_min, y_max  out  YW  bounding box rows (inclusive)
- found  out  1  at least one foreground pixel seen
- done  out  1  results valid; level

## Operation

- States: IDLE, SCAN, DRAIN, FINISH, DONE.
- IDLE: start=1 → clear running min/max (min regs to max value, max regs to 0), clear found_r, x=y=0, done=0, go SCAN.
- SCAN: each cycle drive rd_addr = y*WIDTH+x, register (x,y) into a 1-deep tag pipe with valid bit; advance x, wrap to 0 and increment y at x=WIDTH-1. After issuing address WIDTH*HEIGHT-1 go DRAIN.
- Compare stage (active in SCAN and DRAIN when tag valid): if rd_data < THRESHOLD, update mins/maxes with tagged (x,y), set found_r.
- DRAIN: processes last pixel; go FINISH.
- FINISH: load output registers from running values; if found_r=0 all four coordinates = 0; go DONE.
- DONE: done=1 and outputs held stable. start=1 restarts exactly as from IDLE (done drops next cycle). start ignored in SCAN/DRAIN/FINISH.
- Coordinate arithmetic is unsigned; counters never exceed WIDTH-1 / HEIGHT-1; address computed with AW bits, no overflow.
- Reset (KEY[3]=0), any time including mid-scan: state IDLE, rd_addr=0, all coordinate outputs 0, found=0, done=0 immediately (asynchronous).

## Timing

- Start sampled at edge 0; addresses 0..N-1 (N = WIDTH*HEIGHT) on edges 1..N; DRAIN at edge N+1; FINISH at edge N+2; done=1 visible after edge N+2 — i.e. N+2 cycles start-to-done, identical with or without the margin feature.
- Memory read latency fixed at exactly 1 cycle; no stall input.
- Outputs change only in FINISH or on reset/restart; stable for whole DONE interval.

## Configuration

- BBOX_MARGIN_EN defined: in FINISH, when found_r=1, x_min = max(x_min−MARGIN,0), y_min = max(y_min−MARGIN,0), x_max = min(x_max+MARGIN,WIDTH−1), y_max = min(y_max+MARGIN,HEIGHT−1); clamping done in widened arithmetic, no wrap. found_r=0 still yields all zeros.
- Undefined: tight box, no margin logic synthesized.

## Test plan

- WIDTH=HEIGHT=4, all pixels 8'hFF, start pulse → done after 18 cycles, found=0, all coordinates 0.
- 4x4, single pixel 8'h00 at (x=2,y=1) → x_min=x_max=2, y_min=y_max=1, found=1; with BBOX_MARGIN_EN, MARGIN=2 → x 0..3, y 0..3.
- 4x4, dark pixels only at (0,0) and (3,3) → box 0..3 × 0..3; pixel value exactly THRESHOLD (128) elsewhere → not counted.
- 256x256 triangle.hex loaded into pixel memory → box matches MATLAB-computed extents, done at cycle 65538.
- Reset KEY[3] low at cycle 10 of a 4x4 scan → done=0, outputs 0 immediately; restart → correct result after 18 cycles.
- start held high through SCAN and pulsed again in DONE → first scan unaffected, second scan restarts, done drops one cycle after start.

Source files
------------

// File: rtl/bbox_scan.sv
// Bounding-box scanner: one pixel per clock, finds extents of dark pixels.
// Optional BBOX_MARGIN_EN pads the reported box by MARGIN, clamped to the image.
module bbox_scan #(
    parameter int          WIDTH     = 256,
    parameter int          HEIGHT    = 256,
    parameter logic [7:0]  THRESHOLD = 8'd128,
    parameter int          MARGIN    = 2,
    localparam int         XW        = $clog2(WIDTH),
    localparam int         YW        = $clog2(HEIGHT),
    localparam int         AW        = $clog2(WIDTH * HEIGHT)
) (
    input  logic          CLOCK_50,
    input  logic [3:0]    KEY,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic          found,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_FINISH, S_DONE
    } state_t;

    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);

    logic clk, rst_n;
    logic unused_key;
    assign clk        = CLOCK_50;
    assign rst_n      = KEY[3];
    assign unused_key = ^KEY[2:0];

    state_t state, state_nx;

    logic [XW-1:0] x_cnt, tag_x, rx_min, rx_max, fx_min, fx_max;
    logic [YW-1:0] y_cnt, tag_y, ry_min, ry_max, fy_min, fy_max;
    logic          tag_v, found_r, scan_go, last_pix, hit;

    assign scan_go  = start && (state == S_IDLE || state == S_DONE);
    assign last_pix = (state == S_SCAN) && x_cnt == XLAST
                      && y_cnt == YLAST;
    assign hit      = tag_v && (rd_data < THRESHOLD)
                      && (state == S_SCAN || state == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start)    state_nx = S_SCAN;
            S_SCAN:   if (last_pix) state_nx = S_DRAIN;
            S_DRAIN:                state_nx = S_FINISH;
            S_FINISH:               state_nx = S_DONE;
            S_DONE:   if (start)    state_nx = S_SCAN;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        done    = (state == S_DONE);
        rd_addr = AW'(y_cnt) * AW'(WIDTH) + AW'(x_cnt);
    end

    // Scan counters and the 1-deep tag pipe matching read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            tag_v <= 1'b0;
            tag_x <= '0;
            tag_y <= '0;
        end else begin
            tag_v <= (state == S_SCAN);
            tag_x <= x_cnt;
            tag_y <= y_cnt;
            if (scan_go || last_pix) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (state == S_SCAN) begin
                if (x_cnt == XLAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_min  <= '1;
            rx_max  <= '0;
            ry_min  <= '1;
            ry_max  <= '0;
            found_r <= 1'b0;
        end else if (scan_go) begin
            rx_min  <= '1;
            rx_max  <= '0;
            ry_min  <= '1;
            ry_max  <= '0;
            found_r <= 1'b0;
        end else if (hit) begin
            if (tag_x < rx_min) rx_min <= tag_x;
            if (tag_x > rx_max) rx_max <= tag_x;
            if (tag_y < ry_min) ry_min <= tag_y;
            if (tag_y > ry_max) ry_max <= tag_y;
            found_r <= 1'b1;
        end
    end

`ifdef BBOX_MARGIN_EN
    // Widened int arithmetic so the padding clamps instead of wrapping
    always_comb begin
        fx_min = (int'(rx_min) >= MARGIN) ? XW'(int'(rx_min) - MARGIN) : '0;
        fy_min = (int'(ry_min) >= MARGIN) ? YW'(int'(ry_min) - MARGIN) : '0;
        fx_max = (int'(rx_max) + MARGIN > WIDTH - 1) ? XLAST
                 : XW'(int'(rx_max) + MARGIN);
        fy_max = (int'(ry_max) + MARGIN > HEIGHT - 1) ? YLAST
                 : YW'(int'(ry_max) + MARGIN);
    end
`else
    logic unused_margin;
    assign unused_margin = (MARGIN != 0);
    always_comb begin
        fx_min = rx_min;
        fx_max = rx_max;
        fy_min = ry_min;
        fy_max = ry_max;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
            found <= 1'b0;
        end else if (state == S_FINISH) begin
            found <= found_r;
            x_min <= found_r ? fx_min : '0;
            x_max <= found_r ? fx_max : '0;
            y_min <= found_r ? fy_min : '0;
            y_max <= found_r ? fy_max : '0;
        end
    end

endmodule

// File: tb/tb_bbox_scan.sv
// Directed bench for bbox_scan on a 4x4 image with a 1-cycle pixel memory.
// Expected boxes follow BBOX_MARGIN_EN when the bench is built with it.
module tb_bbox_scan;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY      = 4'hF;
    logic       start    = 1'b0;
    logic [3:0] rd_addr;
    logic [7:0] rd_data  = 8'h00;
    logic [1:0] x_min, x_max, y_min, y_max;
    logic       found, done;

    logic [7:0] mem [16];
    int vecs = 0;
    int errs = 0;

    bbox_scan #(.WIDTH(4), .HEIGHT(4), .THRESHOLD(8'd128), .MARGIN(2)) dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .found(found), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rd_data <= mem[rd_addr];

    function automatic logic [9:0] res();
        return {done, found, x_min, x_max, y_min, y_max};
    endfunction

    task automatic fill(input logic [7:0] bg);
        for (int i = 0; i < 16; i++) mem[i] = bg;
    endtask

    // Caller is #1 past a rising edge; start is sampled at the next edge
    task automatic run_scan(input int hold, output int cyc, output logic d0);
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        d0 = done;
        if (hold == 0) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge CLOCK_50); #1;
            cyc++;
            if (cyc >= hold) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        KEY = 4'h7;
        #1;
        vecs++;
        if ({res(), rd_addr} !== 14'h0) begin
            errs++;
            $display("FAIL reset: got %h want 0", {res(), rd_addr});
        end
        @(posedge CLOCK_50); #1;
        KEY = 4'hF;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_empty();
        int c; logic d0;
        fill(8'hFF);
        run_scan(0, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL empty_lat: got %0d want 18", c);
        end
        vecs++;
        if (res() !== 10'b10_00_00_00_00) begin
            errs++; $display("FAIL empty_box: got %b want 1000000000", res());
        end
    endtask

    task automatic test_single();
        int c; logic d0; logic [9:0] exp_r;
        fill(8'hFF);
        mem[6] = 8'h00;
`ifdef BBOX_MARGIN_EN
        exp_r = {2'b11, 2'd0, 2'd3, 2'd0, 2'd3};
`else
        exp_r = {2'b11, 2'd2, 2'd2, 2'd1, 2'd1};
`endif
        run_scan(0, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL single_lat: got %0d want 18", c);
        end
        vecs++;
        if (res() !== exp_r) begin
            errs++; $display("FAIL single_box: got %b want %b", res(), exp_r);
        end
    endtask

    task automatic test_corners();
        int c; logic d0;
        fill(8'd128);
        mem[0]  = 8'h00;
        mem[15] = 8'h00;
        run_scan(0, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL corners_lat: got %0d want 18", c);
        end
        vecs++;
        if (res() !== {2'b11, 2'd0, 2'd3, 2'd0, 2'd3}) begin
            errs++; $display("FAIL corners_box: got %b want 1100110011", res());
        end
    endtask

    task automatic test_threshold();
        int c; logic d0; logic [9:0] exp_r;
        fill(8'd128);
        mem[9] = 8'd127;
`ifdef BBOX_MARGIN_EN
        exp_r = {2'b11, 2'd0, 2'd3, 2'd0, 2'd3};
`else
        exp_r = {2'b11, 2'd1, 2'd1, 2'd2, 2'd2};
`endif
        run_scan(0, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL thresh_lat: got %0d want 18", c);
        end
        vecs++;
        if (res() !== exp_r) begin
            errs++; $display("FAIL thresh_box: got %b want %b", res(), exp_r);
        end
    endtask

    task automatic test_reset_mid();
        int c; logic d0; logic [9:0] exp_r;
        fill(8'hFF);
        mem[6] = 8'h00;
`ifdef BBOX_MARGIN_EN
        exp_r = {2'b11, 2'd0, 2'd3, 2'd0, 2'd3};
`else
        exp_r = {2'b11, 2'd2, 2'd2, 2'd1, 2'd1};
`endif
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (9) @(posedge CLOCK_50);
        #3 KEY = 4'h7;
        #1;
        vecs++;
        if ({res(), rd_addr} !== 14'h0) begin
            errs++;
            $display("FAIL midreset: got %h want 0", {res(), rd_addr});
        end
        @(posedge CLOCK_50); #1;
        KEY = 4'hF;
        @(posedge CLOCK_50); #1;
        run_scan(0, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL midreset_lat: got %0d want 18", c);
        end
        vecs++;
        if (res() !== exp_r) begin
            errs++; $display("FAIL midreset_box: got %b want %b", res(), exp_r);
        end
    endtask

    task automatic test_back_to_back();
        int c; logic d0; logic [9:0] ea, eb;
`ifdef BBOX_MARGIN_EN
        ea = {2'b11, 2'd1, 2'd3, 2'd0, 2'd2};
        eb = {2'b11, 2'd0, 2'd2, 2'd1, 2'd3};
`else
        ea = {2'b11, 2'd3, 2'd3, 2'd0, 2'd0};
        eb = {2'b11, 2'd0, 2'd0, 2'd3, 2'd3};
`endif
        fill(8'hFF);
        mem[3] = 8'h10;
        run_scan(10, c, d0);
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL b2b_lat1: got %0d want 18", c);
        end
        vecs++;
        if (res() !== ea) begin
            errs++; $display("FAIL b2b_box1: got %b want %b", res(), ea);
        end
        fill(8'hFF);
        mem[12] = 8'h7F;
        run_scan(0, c, d0);
        vecs++;
        if (d0 !== 1'b0) begin
            errs++; $display("FAIL b2b_drop: got done=%b want 0", d0);
        end
        vecs++;
        if (c !== 18) begin
            errs++; $display("FAIL b2b_lat2: got %0d want 18", c);
        end
        vecs++;
        if (res() !== eb) begin
            errs++; $display("FAIL b2b_box2: got %b want %b", res(), eb);
        end
    endtask

    initial begin
        fill(8'hFF);
        #2;
        test_reset();
        test_empty();
        test_single();
        test_corners();
        test_threshold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
